// File: rtl/scr1_irq_gen.sv
// SoC-side IRQ source for the core's 16-line interrupt controller: event, software and timer
// sources feed per-line pending bits, presented as level or fixed-width pulse. Timer built with SCR1_IRQ_GEN_TIMER_EN.
module scr1_irq_gen #(
  parameter int unsigned LINES   = 16,
  parameter int unsigned PULSE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [2:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             ack_o,
  input  logic [LINES-1:0] ev_i,
  output logic [LINES-1:0] irq_lines_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } pulse_st_e;

  logic [LINES-1:0] r_sync1, r_sync2, r_dly;
  logic [LINES-1:0] r_pend, r_mode, r_ena, r_irq;
  logic             r_ack;
  logic [31:0]      r_rdata;
  pulse_st_e        r_st     [LINES];
  pulse_st_e        w_st_nx  [LINES];
  logic [3:0]       r_cnt    [LINES];
  logic [3:0]       w_cnt_nx [LINES];
  logic [LINES-1:0] w_start, w_set, w_clr, w_tset, w_irq_nx;
  logic             w_acc, w_wr;
  logic [31:0]      w_rdata;

  // A request seen on the ack edge is the tail of the finished access, not a new one
  assign w_acc = req_i & ~r_ack;
  assign w_wr  = w_acc & we_i;

`ifdef SCR1_IRQ_GEN_TIMER_EN
  logic [31:0] r_tcmp, r_tcnt;
  logic        r_ten;
  logic [3:0]  r_tline;
  logic        w_tmatch;

  assign w_tmatch = r_ten & (r_tcnt == r_tcmp);
  assign w_tset   = w_tmatch ? ({{(LINES-1){1'b0}}, 1'b1} << r_tline) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcmp  <= '0;
      r_tcnt  <= '0;
      r_ten   <= 1'b0;
      r_tline <= '0;
    end else begin
      if (!r_ten || w_tmatch) r_tcnt <= '0;
      else                    r_tcnt <= r_tcnt + 32'd1;
      if (w_wr && addr_i == 3'd5) r_tcmp <= wdata_i;
      if (w_wr && addr_i == 3'd6) begin
        r_ten   <= wdata_i[0];
        r_tline <= wdata_i[7:4];
      end
    end
  end
`else
  logic w_unused_wdata;
  assign w_tset         = '0;
  assign w_unused_wdata = ^wdata_i[31:LINES];
`endif

  always_comb begin
    w_rdata = '0;
    case (addr_i)
      3'd2: w_rdata[LINES-1:0] = r_pend;
      3'd3: w_rdata[LINES-1:0] = r_mode;
      3'd4: w_rdata[LINES-1:0] = r_ena;
`ifdef SCR1_IRQ_GEN_TIMER_EN
      3'd5: w_rdata = r_tcmp;
      3'd6: w_rdata = {24'd0, r_tline, 3'd0, r_ten};
      3'd7: w_rdata = r_tcnt;
`endif
      default: w_rdata = '0;
    endcase
  end

  // Sets always beat clears, including the clear issued when a pulse starts
  assign w_set = (r_sync2 & ~r_dly) | w_tset
               | ((w_wr && addr_i == 3'd0) ? wdata_i[LINES-1:0] : '0);
  assign w_clr = ((w_wr && addr_i == 3'd1) ? wdata_i[LINES-1:0] : '0) | w_start;

  always_comb begin
    for (int unsigned i = 0; i < LINES; i++) begin
      w_st_nx[i]  = r_st[i];
      w_cnt_nx[i] = r_cnt[i];
      w_start[i]  = 1'b0;
      if (!r_mode[i] || !r_ena[i]) begin
        w_st_nx[i] = ST_IDLE;
      end else begin
        case (r_st[i])
          ST_IDLE: w_start[i] = r_pend[i];
          ST_HIGH: begin
            if (r_cnt[i] == 4'd1) w_st_nx[i]  = ST_GAP;
            else                  w_cnt_nx[i] = r_cnt[i] - 4'd1;
          end
          // GAP restarts directly so back-to-back pulses repeat every PULSE_W+1 cycles
          ST_GAP: begin
            w_start[i] = r_pend[i];
            w_st_nx[i] = ST_IDLE;
          end
          default: w_st_nx[i] = ST_IDLE;
        endcase
        if (w_start[i]) begin
          w_st_nx[i]  = ST_HIGH;
          w_cnt_nx[i] = 4'(PULSE_W);
        end
      end
      w_irq_nx[i] = r_mode[i] ? (w_st_nx[i] == ST_HIGH) : (r_pend[i] & r_ena[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LINES; i++) begin
        r_st[i]  <= ST_IDLE;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < LINES; i++) begin
        r_st[i]  <= w_st_nx[i];
        r_cnt[i] <= w_cnt_nx[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_dly   <= '0;
      r_pend  <= '0;
      r_mode  <= '0;
      r_ena   <= '0;
      r_irq   <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_sync1 <= ev_i;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
      r_pend  <= w_set | (r_pend & ~w_clr);
      if (w_wr && addr_i == 3'd3) r_mode <= wdata_i[LINES-1:0];
      if (w_wr && addr_i == 3'd4) r_ena  <= wdata_i[LINES-1:0];
      r_irq   <= w_irq_nx;
      r_ack   <= w_acc;
      r_rdata <= (w_acc && !we_i) ? w_rdata : '0;
    end
  end

  assign rdata_o     = r_rdata;
  assign ack_o       = r_ack;
  assign irq_lines_o = r_irq;

endmodule

// File: tb/tb_scr1_irq_gen.sv
// Self-checking bench for scr1_irq_gen: directed scenarios plus randomized register/event traffic
// compared every cycle against a cycle-stamped behavioural model.
module tb_scr1_irq_gen;
  localparam int PW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [2:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic [15:0] ev_i = '0;
  logic [15:0] irq_lines_o;

  always #5 clk = ~clk;

  scr1_irq_gen #(.LINES(16), .PULSE_W(PW)) u_dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o), .ev_i(ev_i),
    .irq_lines_o(irq_lines_o)
  );

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0, ev_rand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: pulse lines tracked by the cycle their pulse started
  longint      cyc;
  longint      m_start [16];
  logic [15:0] m_pend, m_mode, m_ena, m_irq, ev_a, ev_b, ev_c;
  logic        m_ack, m_ten;
  logic [31:0] m_rdata, m_tcmp, m_tcnt;
  logic [3:0]  m_tline;

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd2: return {16'd0, m_pend};
      3'd3: return {16'd0, m_mode};
      3'd4: return {16'd0, m_ena};
`ifdef SCR1_IRQ_GEN_TIMER_EN
      3'd5: return m_tcmp;
      3'd6: return {24'd0, m_tline, 3'd0, m_ten};
      3'd7: return m_tcnt;
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [15:0] setv, clrv, irqn, tset;
    logic        acc, wr, en;
    logic [31:0] tcnt_n;
    if (rst) begin
      cyc = 0; m_pend = '0; m_mode = '0; m_ena = '0; m_irq = '0;
      ev_a = '0; ev_b = '0; ev_c = '0; m_ack = 1'b0; m_rdata = '0;
      m_ten = 1'b0; m_tcmp = '0; m_tcnt = '0; m_tline = '0;
      for (int i = 0; i < 16; i++) m_start[i] = -100;
    end else begin
      cyc++;
      acc = req_i && !m_ack;
      wr  = acc && we_i;
      tset = '0;
      tcnt_n = '0;
`ifdef SCR1_IRQ_GEN_TIMER_EN
      if (m_ten) begin
        if (m_tcnt == m_tcmp) tset = 16'd1 << m_tline;
        else                  tcnt_n = m_tcnt + 1;
      end
`endif
      setv = (ev_b & ~ev_c) | tset | ((wr && addr_i == 3'd0) ? wdata_i[15:0] : 16'd0);
      clrv = (wr && addr_i == 3'd1) ? wdata_i[15:0] : 16'd0;
      for (int i = 0; i < 16; i++) begin
        en = m_mode[i] & m_ena[i];
        if (!en) m_start[i] = -100;
        else if (m_pend[i] && cyc >= m_start[i] + PW + 1) begin
          clrv[i] = 1'b1;
          m_start[i] = cyc;
        end
        irqn[i] = m_mode[i] ? (en && (cyc - m_start[i] < PW)) : (m_pend[i] & m_ena[i]);
      end
      m_rdata = (acc && !we_i) ? m_read(addr_i) : 32'd0;
      m_ack   = acc;
      m_pend  = setv | (m_pend & ~clrv);
      m_tcnt  = tcnt_n;
      if (wr && addr_i == 3'd3) m_mode = wdata_i[15:0];
      if (wr && addr_i == 3'd4) m_ena  = wdata_i[15:0];
`ifdef SCR1_IRQ_GEN_TIMER_EN
      if (wr && addr_i == 3'd5) m_tcmp = wdata_i;
      if (wr && addr_i == 3'd6) begin m_ten = wdata_i[0]; m_tline = wdata_i[7:4]; end
`endif
      m_irq = irqn;
      ev_c = ev_b; ev_b = ev_a; ev_a = ev_i;
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("cyc_irq", {16'd0, irq_lines_o}, {16'd0, m_irq});
      chk("cyc_ack", {31'd0, ack_o}, {31'd0, m_ack});
      chk("cyc_rdata", rdata_o, m_rdata);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (ev_rand) ev_i = ev_i ^ 16'($urandom & $urandom & $urandom);
  endtask

  task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                     output logic [31:0] q);
    int n;
    tick();
    req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
    n = 0;
    do begin tick(); n++; end while (!ack_o && n < 4);
    chk("bus_ack", {31'd0, ack_o}, 32'd1);
    q = rdata_o;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(1'b1, a, d, q);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, d;
    logic [2:0]  a;
    logic        found;
    bit          samp[$];
    int          r1[$], g0[$], rises[$];
    int          c1, c0;

    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    tick();
    chk("rst_irq", {16'd0, irq_lines_o}, 32'd0);
    bus(1'b0, 3'd2, 32'd0, q);
    chk("rst_pend", q, 32'd0);

    wr(3'd4, 32'hFFFF);
    wr(3'd0, 32'h5);
    tick();
    chk("set_level", {16'd0, irq_lines_o}, 32'h5);
    wr(3'd1, 32'h1);
    tick();
    chk("clr_level", {16'd0, irq_lines_o}, 32'h4);

    wr(3'd3, 32'h8);
    fork
      for (int k = 0; k < 18; k++) begin @(negedge clk); samp.push_back(irq_lines_o[3]); end
      begin wr(3'd0, 32'h8); wr(3'd0, 32'h8); end
    join
    c1 = 0; c0 = 0;
    foreach (samp[k]) begin
      if (samp[k]) begin
        if (c0 > 0 && r1.size() > 0) g0.push_back(c0);
        c0 = 0; c1++;
      end else begin
        if (c1 > 0) r1.push_back(c1);
        c1 = 0; c0++;
      end
    end
    if (c1 > 0) r1.push_back(c1);
    chk("pulse_count", r1.size(), 2);
    chk("pulse_w0", (r1.size() > 0) ? r1[0] : 0, PW);
    chk("pulse_w1", (r1.size() > 1) ? r1[1] : 0, PW);
    chk("pulse_gap", (g0.size() > 0) ? g0[0] : 0, 1);
    bus(1'b0, 3'd2, 32'd0, q);
    chk("pend_after_pulse", q, 32'h4);

    ev_i[7] = 1'b1;
    repeat (3) tick();
    chk("ev_early", {31'd0, irq_lines_o[7]}, 32'd0);
    tick();
    chk("ev_rise", {31'd0, irq_lines_o[7]}, 32'd1);
    wr(3'd1, 32'h80);
    tick(); tick();
    chk("ev_held", {31'd0, irq_lines_o[7]}, 32'd0);
    ev_i[7] = 1'b0;
    repeat (4) tick();
    ev_i[7] = 1'b1;
    repeat (4) tick();
    chk("ev_rerise", {31'd0, irq_lines_o[7]}, 32'd1);
    wr(3'd1, 32'h80);

    wr(3'd4, 32'hFFFB);
    tick();
    chk("ena_off", {31'd0, irq_lines_o[2]}, 32'd0);
    wr(3'd4, 32'hFFFF);
    tick();
    chk("ena_on", {31'd0, irq_lines_o[2]}, 32'd1);
    bus(1'b0, 3'd2, 32'd0, q);
    chk("pend_kept", q, 32'h4);

`ifdef SCR1_IRQ_GEN_TIMER_EN
    wr(3'd3, 32'h20);
    wr(3'd5, 32'd9);
    wr(3'd6, 32'h51);
    c0 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (irq_lines_o[5] && c0 == 0) rises.push_back(k);
      c0 = irq_lines_o[5];
    end
    chk("tmr_period0", (rises.size() > 1) ? rises[1] - rises[0] : 0, 10);
    chk("tmr_period1", (rises.size() > 2) ? rises[2] - rises[1] : 0, 10);
    wr(3'd6, 32'h0);
    wr(3'd3, 32'h0);
    wr(3'd1, 32'h20);
    wr(3'd6, 32'h51);
    repeat (8) tick();
    wr(3'd1, 32'h20);
    bus(1'b0, 3'd2, 32'd0, q);
    chk("tmr_set_beats_clr", q & 32'h20, 32'h20);
    wr(3'd6, 32'h0);
    wr(3'd1, 32'h20);
`else
    for (int k = 5; k < 8; k++) begin
      a = 3'(k);
      wr(a, 32'hFFFF_FFFF);
      bus(1'b0, a, 32'd0, q);
      chk("notimer_read", q, 32'd0);
    end
`endif

    ev_rand = 1'b1;
    for (int n = 0; n < 500; n++) begin
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      case (a)
        3'd4: if ($urandom_range(0, 3) != 0) d = 32'hFFFF;
        3'd5: d = $urandom_range(0, 15);
        3'd6: d = d & 32'hF1;
        default: ;
      endcase
      bus(1'($urandom_range(0, 1)), a, d, q);
      repeat ($urandom_range(0, 3)) tick();
    end

    ev_rand = 1'b0;
    ev_i = '0;
    wr(3'd6, 32'h0);
    wr(3'd3, 32'h8);
    wr(3'd4, 32'hFFFF);
    wr(3'd0, 32'h8);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      found = irq_lines_o[3];
    end
    chk("pulse_seen", {31'd0, found}, 32'd1);
    req_i = 1'b1; we_i = 1'b0; addr_i = 3'd2;
    #2 rst = 1'b1;
    #1;
    chk("rst_irq_now", {16'd0, irq_lines_o}, 32'd0);
    chk("rst_ack_now", {31'd0, ack_o}, 32'd0);
    tick();
    chk("rst_ack_hold", {31'd0, ack_o}, 32'd0);
    tick();
    req_i = 1'b0;
    #2 rst = 1'b0;
    tick();
    chk("post_rst_ack", {31'd0, ack_o}, 32'd0);
    chk("post_rst_irq", {16'd0, irq_lines_o}, 32'd0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
